// File: rtl/lcd_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lcd_frame_writer : decodes LCD controller commands and turns RGB565 pixel
//                    words into frame-RAM writes inside a wrapping window.
// Rev 1.0
// ============================================================================
module lcd_frame_writer #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              i_Mode,
   input  logic [15:0]       i_Data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_wr_valid,
   input  logic              i_wr_ready,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [15:0]       o_wr_data,
   output logic              o_frame_done
);
   localparam int          CW     = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int          RW     = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [15:0] C_HMAX = 16'(H_RES - 1);
   localparam logic [15:0] C_VMAX = 16'(V_RES - 1);

   typedef enum logic [2:0] {IDLE, CA_SC, CA_EC, PA_SP, PA_EP, RAMWR, SKIP} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     sc_q, sc_d, ec_q, ec_d, col_q, col_d;
   logic [RW-1:0]     sp_q, sp_d, ep_q, ep_d, row_q, row_d;
   logic [15:0]       psc_q, psc_d, psp_q, psp_d;
   logic              wr_valid_q, wr_valid_d, done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       data_q, data_d;

   logic              accept;
   logic [15:0]       ec_clamp, sc_clamp, ep_clamp, sp_clamp;
   logic [ADDR_W-1:0] pix_addr;

   assign o_ready      = !wr_valid_q || i_wr_ready;
   assign accept       = i_valid && o_ready;
   assign o_wr_valid   = wr_valid_q;
   assign o_wr_addr    = addr_q;
   assign o_wr_data    = data_q;
   assign o_frame_done = done_q;

   // End is clamped to the panel first; start is then clamped to the new end.
   assign ec_clamp = (i_Data > C_HMAX) ? C_HMAX : i_Data;
   assign sc_clamp = (psc_q > ec_clamp) ? ec_clamp : psc_q;
   assign ep_clamp = (i_Data > C_VMAX) ? C_VMAX : i_Data;
   assign sp_clamp = (psp_q > ep_clamp) ? ep_clamp : psp_q;

   assign pix_addr = ADDR_W'(row_q) * ADDR_W'(H_RES) + ADDR_W'(col_q);

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sc_q       <= '0;
         ec_q       <= CW'(H_RES - 1);
         sp_q       <= '0;
         ep_q       <= RW'(V_RES - 1);
         col_q      <= '0;
         row_q      <= '0;
         psc_q      <= '0;
         psp_q      <= '0;
         wr_valid_q <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         sc_q       <= sc_d;
         ec_q       <= ec_d;
         sp_q       <= sp_d;
         ep_q       <= ep_d;
         col_q      <= col_d;
         row_q      <= row_d;
         psc_q      <= psc_d;
         psp_q      <= psp_d;
         wr_valid_q <= wr_valid_d;
         done_q     <= done_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sc_d       = sc_q;
      ec_d       = ec_q;
      sp_d       = sp_q;
      ep_d       = ep_q;
      col_d      = col_q;
      row_d      = row_q;
      psc_d      = psc_q;
      psp_d      = psp_q;
      wr_valid_d = wr_valid_q && !i_wr_ready;
      done_d     = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;

      if (accept && i_Mode) begin
         case (i_Data[15:8])
            8'h2A: state_d = CA_SC;
            8'h2B: state_d = PA_SP;
            8'h2C: begin
               state_d = RAMWR;
               col_d   = sc_q;
               row_d   = sp_q;
            end
            8'h01: begin
               state_d = IDLE;
               sc_d    = '0;
               ec_d    = CW'(H_RES - 1);
               sp_d    = '0;
               ep_d    = RW'(V_RES - 1);
            end
            8'h00:   state_d = IDLE;
            default: state_d = SKIP;
         endcase
      end else if (accept) begin
         case (state_q)
            CA_SC: begin
               psc_d   = i_Data;
               state_d = CA_EC;
            end
            CA_EC: begin
               ec_d    = CW'(ec_clamp);
               sc_d    = CW'(sc_clamp);
               state_d = IDLE;
            end
            PA_SP: begin
               psp_d   = i_Data;
               state_d = PA_EP;
            end
            PA_EP: begin
               ep_d    = RW'(ep_clamp);
               sp_d    = RW'(sp_clamp);
               state_d = IDLE;
            end
            RAMWR: begin
               wr_valid_d = 1'b1;
               addr_d     = pix_addr;
               data_d     = i_Data;
               if (col_q == ec_q) begin
                  col_d = sc_q;
                  if (row_q == ep_q) begin
                     row_d  = sp_q;
                     done_d = 1'b1;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_lcd_frame_writer : directed command/pixel streams against a cycle model
//                       of the window cursor, plus literal address checks.
// Rev 1.0
// ============================================================================
module tb_lcd_frame_writer;
   localparam int H  = 320;
   localparam int V  = 240;
   localparam int AW = 17;

   logic          CLK = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_Mode = 1'b0;
   logic [15:0]   i_Data = '0;
   logic          i_valid = 1'b0;
   logic          i_wr_ready = 1'b1;
   logic          o_ready, o_wr_valid, o_frame_done;
   logic [AW-1:0] o_wr_addr;
   logic [15:0]   o_wr_data;

   int total = 0;
   int bad   = 0;
   int wlog[$];
   int done_cnt = 0;
   int done_at  = -1;

   // Reference model: 0 idle, 1 col start, 2 col end, 3 page start, 4 page end, 5 pixels, 6 skip
   int m_st = 0;
   int sc = 0, ec = H - 1, sp = 0, ep = V - 1, psc = 0, psp = 0, col = 0, row = 0;
   bit m_valid = 0, m_done = 0, m_acc = 0;
   int m_addr = 0, m_data = 0;

   lcd_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
      .CLK          (CLK),
      .rst_n        (rst_n),
      .i_Mode       (i_Mode),
      .i_Data       (i_Data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_wr_valid   (o_wr_valid),
      .i_wr_ready   (i_wr_ready),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_frame_done (o_frame_done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic chk_log(input string name, input int idx, input int exp);
      int act;
      act = (idx < wlog.size()) ? wlog[idx] : -1;
      chk(name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic m, input logic [15:0] d);
      int n;
      i_Mode = m; i_Data = d; i_valid = 1'b1;
      n = 0;
      #1;
      while (!o_ready && n < 50) begin
         @(negedge CLK); #1; n++;
      end
      if (!o_ready) begin
         total++; bad++;
         $display("FAIL send_timeout: o_ready=0 required 1");
      end
      @(negedge CLK);
      i_valid = 1'b0;
   endtask

   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; sc = 0; ec = H - 1; sp = 0; ep = V - 1; col = 0; row = 0;
         m_valid = 0; m_done = 0; m_addr = 0; m_data = 0;
      end else begin
         m_acc  = i_valid && (!m_valid || i_wr_ready);
         m_done = 0;
         if (m_valid && i_wr_ready) m_valid = 0;
         if (m_acc && i_Mode) begin
            case (i_Data[15:8])
               8'h2A: m_st = 1;
               8'h2B: m_st = 3;
               8'h2C: begin m_st = 5; col = sc; row = sp; end
               8'h01: begin m_st = 0; sc = 0; ec = H - 1; sp = 0; ep = V - 1; end
               8'h00: m_st = 0;
               default: m_st = 6;
            endcase
         end else if (m_acc) begin
            case (m_st)
               1: begin psc = int'(i_Data); m_st = 2; end
               2: begin
                  ec = (int'(i_Data) > H - 1) ? H - 1 : int'(i_Data);
                  sc = (psc > ec) ? ec : psc;
                  m_st = 0;
               end
               3: begin psp = int'(i_Data); m_st = 4; end
               4: begin
                  ep = (int'(i_Data) > V - 1) ? V - 1 : int'(i_Data);
                  sp = (psp > ep) ? ep : psp;
                  m_st = 0;
               end
               5: begin
                  m_valid = 1;
                  m_addr  = row * H + col;
                  m_data  = int'(i_Data);
                  if (col == ec) begin
                     col = sc;
                     if (row == ep) begin row = sp; m_done = 1; end
                     else row = row + 1;
                  end else begin
                     col = col + 1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge CLK) begin
      #2;
      if (rst_n) begin
         chk("ready", o_ready, (!m_valid || i_wr_ready));
         chk("wr_valid", o_wr_valid, m_valid);
         if (m_valid) begin
            chk("wr_addr", o_wr_addr, m_addr);
            chk("wr_data", o_wr_data, m_data);
         end
         chk("frame_done", o_frame_done, m_done);
         if (o_wr_valid && i_wr_ready) wlog.push_back(int'(o_wr_addr));
         if (o_frame_done) begin done_cnt++; done_at = wlog.size(); end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge CLK);
      rst_n = 1'b1;
      #1;
      chk("rst_wr_valid", o_wr_valid, 0);
      chk("rst_wr_addr", o_wr_addr, 0);
      chk("rst_wr_data", o_wr_data, 0);
      chk("rst_frame_done", o_frame_done, 0);
      chk("rst_ready", o_ready, 1);
      @(negedge CLK);

      // Default window, three pixels from the origin
      send(1'b1, 16'h2C00);
      send(1'b0, 16'hF800);
      send(1'b0, 16'h07E0);
      send(1'b0, 16'h001F);
      idle(3);
      chk_log("s1_addr0", 0, 0);
      chk_log("s1_addr1", 1, 1);
      chk_log("s1_addr2", 2, 2);

      // 3x2 window with wrap back to the start
      send(1'b1, 16'h2A00); send(1'b0, 16'd10); send(1'b0, 16'd12);
      send(1'b1, 16'h2B00); send(1'b0, 16'd5);  send(1'b0, 16'd6);
      send(1'b1, 16'h2C00);
      for (int k = 0; k < 7; k++) send(1'b0, 16'h1000 + 16'(k));
      idle(3);
      chk_log("s2_a0", 3, 1610);
      chk_log("s2_a1", 4, 1611);
      chk_log("s2_a2", 5, 1612);
      chk_log("s2_a3", 6, 1930);
      chk_log("s2_a4", 7, 1931);
      chk_log("s2_a5", 8, 1932);
      chk_log("s2_a6", 9, 1610);
      chk("s2_done_after_6th", done_at, 9);

      // Software reset, then an oversized column range clamps to the last column
      send(1'b1, 16'h0100);
      send(1'b1, 16'h2A00); send(1'b0, 16'd400); send(1'b0, 16'd500);
      send(1'b1, 16'h2C00);
      send(1'b0, 16'h0001); send(1'b0, 16'h0002);
      idle(3);
      chk_log("s3_a0", 10, 319);
      chk_log("s3_a1", 11, 639);

      // Back-pressure: one pixel held pending for five cycles
      i_wr_ready = 1'b0;
      send(1'b0, 16'hAAAA);
      i_Mode = 1'b0; i_Data = 16'hBBBB; i_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_ready", o_ready, 0);
         chk("stall_addr", o_wr_addr, 959);
         chk("stall_data", o_wr_data, 16'hAAAA);
         @(negedge CLK);
      end
      i_wr_ready = 1'b1;
      @(negedge CLK);
      i_valid = 1'b0;
      idle(3);
      chk("stall_log_size", wlog.size(), 14);
      chk_log("stall_a0", 12, 959);
      chk_log("stall_a1", 13, 1279);

      // Truncated CASET keeps the old window; unknown opcode swallows data
      send(1'b1, 16'h2A00); send(1'b0, 16'd50);
      send(1'b1, 16'h2C00);
      send(1'b0, 16'h5555);
      idle(3);
      chk_log("abort_a0", 14, 319);
      send(1'b1, 16'h3600); send(1'b0, 16'h1111); send(1'b0, 16'h2222);
      idle(3);
      chk("skip_no_write", wlog.size(), 15);
      chk("done_count", done_cnt, 1);

      // Reset while a write is pending drops it and restores the window
      send(1'b1, 16'h2C00);
      i_wr_ready = 1'b0;
      send(1'b0, 16'h1234);
      #1;
      chk("pre_rst_valid", o_wr_valid, 1);
      chk("pre_rst_addr", o_wr_addr, 319);
      rst_n = 1'b0;
      #1;
      chk("rst_drop_valid", o_wr_valid, 0);
      chk("rst_drop_ready", o_ready, 1);
      @(negedge CLK);
      rst_n = 1'b1;
      i_wr_ready = 1'b1;
      send(1'b1, 16'h2C00);
      for (int k = 0; k < 321; k++) send(1'b0, 16'(k));
      idle(3);
      chk_log("post_rst_a0", 15, 0);
      chk_log("post_rst_last_col", 334, 319);
      chk_log("post_rst_row1", 335, 320);
      chk("post_rst_log_size", wlog.size(), 336);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Consumes the 17-bit {mode, data} word stream from the SPI packing stage. Decodes display-controller commands: column address set (0x2A), page address set (0x2B), memory write (0x2C), software reset (0x01) and NOP (0x00). Converts each RGB565 pixel word that follows a memory write into a frame-RAM write at the correct linear address. It sits between the SPI buffer and the frame RAM, and the window cursor wraps the way a standard LCD controller's does.

## Interface
- H_RES, default 320: pixels per line.
- V_RES, default 240: lines per frame.
- ADDR_W, default 17: frame-RAM address width; H_RES*V_RES must not exceed 2^ADDR_W.
- CLK  in  1  single system clock (50 MHz); all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_Mode  in  1  1 = command word, 0 = data word.
- i_Data  in  16  command word: [15:8] = opcode, [7:0] = 0; data word: {first byte, second byte}.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  block accepts a word this cycle.
- o_wr_valid  out  1  frame-RAM write request pending.
- i_wr_ready  in  1  frame RAM accepts the write this cycle.
- o_wr_addr  out  ADDR_W  linear pixel address, row*H_RES + col.
- o_wr_data  out  16  RGB565 pixel.
- o_frame_done  out  1  one-cycle pulse when the last pixel of the window is accepted by the input side.

## Operation
- A word is accepted on an edge where i_valid && o_ready.
- o_ready = !o_wr_valid || i_wr_ready. The output register is single-entry and has no extra buffering.
- Window registers SC, EC, SP, EP. Reset value is 0, H_RES-1, 0, V_RES-1. Cursor registers are col and row.
- States: IDLE, CA_SC, CA_EC, PA_SP, PA_EP, RAMWR, SKIP.
- An accepted command word is decoded in any state and aborts the current command:
  - 0x2A → CA_SC.
  - 0x2B → PA_SP.
  - 0x2C → RAMWR, with col:=SC and row:=SP.
  - 0x01 → window restored to reset values, → IDLE.
  - 0x00 → IDLE.
  - Any other opcode → SKIP.
- CA_SC: data word is latched as pending SC → CA_EC.
- CA_EC: data word becomes EC → IDLE. On this same edge SC and EC commit together. Clamping:
  - EC := min(word, H_RES-1).
  - SC := min(pending SC, clamped EC).
- A CASET aborted before EC leaves the window unchanged.
- PA_SP and PA_EP behave identically, using V_RES-1 for the clamp.
- RAMWR: each data word produces one write at (col,row):
  - Load o_wr_data := word, o_wr_addr := row*H_RES+col, o_wr_valid := 1.
  - Advance the cursor. If col==EC, then col:=SC and row advances.
  - Row advance: if row==EP, then row:=SP and o_frame_done pulses. Otherwise row+1.
- IDLE and SKIP: data words are accepted and discarded, with no write.
- Address arithmetic is unsigned. The product row*H_RES+col must be computed at ADDR_W bits without truncation for all in-range cursors.

## Timing
- Reset values: o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_frame_done=0, state=IDLE, col=0, row=0. o_ready=1 after reset.
- Latency: a pixel accepted at edge N gives o_wr_valid=1 with its address and data from edge N until the edge where i_wr_ready=1.
- o_wr_valid clears on that accepting edge unless a new pixel is accepted on the same edge. A new pixel on that edge reloads the register, which sustains 1 write per cycle.
- o_wr_addr and o_wr_data are held stable while o_wr_valid && !i_wr_ready.
- Commands and window changes do not disturb a pending write. The pending write completes with its original address.
- o_frame_done is high exactly one cycle, following the edge that accepts the window's final pixel.
- rst_n asserted mid-frame immediately clears o_wr_valid. Any pending write is dropped.

## Test plan
- Reset, then 0x2C followed by 3 pixels 0xF800, 0x07E0, 0x001F with i_wr_ready=1 → writes at addr 0, 1, 2 on consecutive cycles.
- CASET 10,12; PASET 5,6; RAMWR with 7 pixels:
  - Required addresses: 1610, 1611, 1612, 1930, 1931, 1932, then 1610.
  - o_frame_done pulses after the 6th pixel.
- CASET 400,500 → SC=EC=319. Follow with RAMWR of 2 pixels → addresses row*320+319 with row advancing: 319, then 639.
- Hold i_wr_ready=0 for 5 cycles with a pixel pending → o_ready=0, addr/data stable, no upstream word consumed. Release → one write occurs and the stream resumes.
- Send CASET with only SC=50, then RAMWR → writes start at the previous SC. Send opcode 0x36 plus 2 data words → no writes occur.
- Assert rst_n low during RAMWR with o_wr_valid=1 → o_wr_valid=0 immediately. After release, the window is 0..319 × 0..239.
